// File: rtl/window_feeder_pkg.sv
// ============================================================================
// window_pkg : geometry, state encoding and word type for window_feeder
// Revision   : 1.0
// ============================================================================
`default_nettype none

package window_pkg;

    localparam int WIN_ROWS   = 80;
    localparam int WIN_WCOLS  = 20;
    localparam int PIX_W      = 8;
    localparam int WORD_W     = 32;
    localparam int WIN_WORDS  = WIN_ROWS * WIN_WCOLS;
    localparam int ADDR_W     = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_REQ   = 2'd2,
        ST_SERVE = 2'd3
    } state_e;

    typedef logic [WORD_W-1:0] word_t;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [6:0] r, input logic [6:0] c);
        return ADDR_W'(r) * ADDR_W'(WIN_WCOLS) + ADDR_W'(c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/window_feeder_if.sv
// ============================================================================
// window_feeder_if : host pixel stream plus consumer window-read port
// Revision         : 1.0
// ============================================================================
`default_nettype none

interface window_feeder_if;
    import window_pkg::*;

    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             pix_ready;
    logic             en;
    logic             ack;
    logic [6:0]       row;
    logic [6:0]       col;
    word_t            input_data;
    logic             done;
    logic [7:0]       frame_cnt;

    // Host and consumer side
    modport master (
        output pix_in, pix_valid, ack, row, col, done,
        input  pix_ready, en, input_data, frame_cnt
    );

    // Feeder side
    modport slave (
        input  pix_in, pix_valid, ack, row, col, done,
        output pix_ready, en, input_data, frame_cnt
    );

endinterface

`default_nettype wire

// File: rtl/window_feeder_ram.sv
// ============================================================================
// window_ram : 1600x32 frame buffer, one write port, synchronous read
// Revision   : 1.0
// ============================================================================
`default_nettype none

module window_ram
    import window_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              we_i,
    input  wire logic [ADDR_W-1:0] waddr_i,
    input  wire word_t             wdata_i,
    input  wire logic [ADDR_W-1:0] raddr_i,
    output word_t                  rdata_o
);

    word_t mem_q [WIN_WORDS];
    word_t rdata_q;

    // Contents deliberately carry no reset so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/window_feeder.sv
// ============================================================================
// window_feeder : packs an 80x80 byte frame into 32-bit words and serves them
//                 to a window consumer. Optional ping-pong: WINDOW_FEEDER_DBUF_EN
// Revision      : 1.0
// ============================================================================
`default_nettype none

module window_feeder
    import window_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst_n,
    window_feeder_if.slave bus
);

`ifdef WINDOW_FEEDER_DBUF_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif

    state_e      state_q;
    logic        pix_ready_q;
    logic        en_q;
    logic [7:0]  frame_cnt_q;
    logic        rd_ok_q;
    logic [1:0]  byte_idx_q;
    logic [4:0]  wcol_q;
    logic [6:0]  wrow_q;
    logic [23:0] pack_q;

    logic              w_xfer, w_word_wr, w_col_last, w_row_last, w_fill_last;
    logic              w_done_srv, w_rd_in, w_cnt_clr, w_wr_bank;
    logic              w_rd_full, w_fill_to_rd, w_next_full, w_pix_ready_d;
    logic [ADDR_W-1:0] w_waddr, w_raddr;
    word_t             w_wdata, w_rdata;
    word_t             w_rdata_bank [NBANK];

    assign w_xfer      = bus.pix_valid & pix_ready_q;
    assign w_word_wr   = w_xfer & (byte_idx_q == 2'd3);
    assign w_col_last  = (wcol_q == 5'(WIN_WCOLS - 1));
    assign w_row_last  = (wrow_q == 7'(WIN_ROWS - 1));
    assign w_fill_last = w_word_wr & w_col_last & w_row_last;
    assign w_done_srv  = (state_q == ST_SERVE) & bus.done;
    assign w_waddr     = word_addr(wrow_q, 7'(wcol_q));
    assign w_wdata     = {pack_q, bus.pix_in};
    assign w_rd_in     = (bus.row < 7'(WIN_ROWS)) & (bus.col < 7'(WIN_WCOLS));
    assign w_raddr     = w_rd_in ? word_addr(bus.row, bus.col) : '0;

`ifdef WINDOW_FEEDER_DBUF_EN
    logic [1:0] full_q, full_d;
    logic       wr_bank_q, rd_bank_q, rd_sel_q;

    always_comb begin
        full_d = full_q;
        if (w_fill_last) full_d[wr_bank_q] = 1'b1;
        if (w_done_srv)  full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_sel_q  <= 1'b0;
        end else begin
            full_q   <= full_d;
            rd_sel_q <= rd_bank_q;
            if (w_fill_last) wr_bank_q <= ~wr_bank_q;
            if (w_done_srv)  rd_bank_q <= ~rd_bank_q;
        end
    end

    // A bank finishing while the other is served becomes the next request
    assign w_rd_full     = full_q[rd_bank_q];
    assign w_fill_to_rd  = w_fill_last & (wr_bank_q == rd_bank_q);
    assign w_next_full   = full_q[~rd_bank_q] | (w_fill_last & (wr_bank_q != rd_bank_q));
    assign w_pix_ready_d = ~&full_d;
    assign w_cnt_clr     = 1'b0;
    assign w_wr_bank     = wr_bank_q;
    assign w_rdata       = w_rdata_bank[rd_sel_q];
`else
    assign w_rd_full     = 1'b0;
    assign w_fill_to_rd  = w_fill_last;
    assign w_next_full   = 1'b0;
    assign w_pix_ready_d = (state_q == ST_IDLE) | ((state_q == ST_FILL) & ~w_fill_last) | w_done_srv;
    assign w_cnt_clr     = w_done_srv;
    assign w_wr_bank     = 1'b0;
    assign w_rdata       = w_rdata_bank[0];
`endif

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        window_ram u_ram (
            .clk     (clk),
            .we_i    (w_word_wr & (w_wr_bank == 1'(b))),
            .waddr_i (w_waddr),
            .wdata_i (w_wdata),
            .raddr_i (w_raddr),
            .rdata_o (w_rdata_bank[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q <= '0;
            wcol_q     <= '0;
            wrow_q     <= '0;
            pack_q     <= '0;
        end else if (w_cnt_clr) begin
            byte_idx_q <= '0;
            wcol_q     <= '0;
            wrow_q     <= '0;
        end else if (w_xfer) begin
            pack_q     <= {pack_q[15:0], bus.pix_in};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (w_word_wr) begin
                if (w_col_last) begin
                    wcol_q <= '0;
                    wrow_q <= w_row_last ? 7'd0 : wrow_q + 7'd1;
                end else begin
                    wcol_q <= wcol_q + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pix_ready_q <= 1'b0;
            en_q        <= 1'b0;
            frame_cnt_q <= '0;
            rd_ok_q     <= 1'b0;
        end else begin
            pix_ready_q <= w_pix_ready_d;
            rd_ok_q     <= w_rd_in;
            unique case (state_q)
                ST_IDLE: state_q <= ST_FILL;
                ST_FILL: begin
                    if (w_fill_to_rd | w_rd_full) begin
                        state_q <= ST_REQ;
                        en_q    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus.ack) begin
                        state_q <= ST_SERVE;
                        en_q    <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    if (bus.done) begin
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        if (w_next_full) begin
                            state_q <= ST_REQ;
                            en_q    <= 1'b1;
                        end else begin
                            state_q <= ST_FILL;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.pix_ready  = pix_ready_q;
    assign bus.en         = en_q;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.input_data = rd_ok_q ? w_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_window_feeder.sv
// ============================================================================
// tb_window_feeder : self-checking bench for window_feeder
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_window_feeder;
    import window_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    window_feeder_if bus();

    window_feeder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Pixels of the most recently streamed frame, in raster order
    logic [7:0] pix_m [6400];

    typedef struct {
        int          row;
        int          col;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [$];

    function automatic logic [31:0] model_word(input int r, input int c);
        int base;
        if (r >= 80 || c >= 20) return 32'h0;
        base = r * 80 + 4 * c;
        return {pix_m[base], pix_m[base + 1], pix_m[base + 2], pix_m[base + 3]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string name, input int r, input int c);
        bus.row = 7'(r);
        bus.col = 7'(c);
        step();
        check(name, bus.input_data, model_word(r, c));
    endtask

    task automatic random_reads(input int n);
        for (int i = 0; i < n; i++) begin
            read_chk("rand_read", int'($urandom_range(0, 85)), int'($urandom_range(0, 23)));
        end
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask

    task automatic pulse_done();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
    endtask

    // Streams pixels until stop_at bytes were accepted or the cycle budget runs out
    task automatic feed(input bit rnd_pix, input bit rnd_valid, input int stop_at,
                        input bit chk_en, input bit chk_ready_hi);
        int         acc;
        int         cyc;
        bit         ready_ok;
        bit         en_low_ok;
        bit         accepted;
        logic       va;
        logic [7:0] v;
        acc = 0; cyc = 0; ready_ok = 1'b1; en_low_ok = 1'b1;
        while (acc < stop_at && cyc < 30000) begin
            va = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            v  = rnd_pix ? 8'($urandom) : 8'(acc);
            if (!bus.pix_ready) ready_ok = 1'b0;
            if (bus.en) en_low_ok = 1'b0;
            bus.pix_valid = va;
            bus.pix_in    = va ? v : 8'($urandom);
            accepted      = va && bus.pix_ready;
            if (accepted) pix_m[acc] = v;
            step();
            cyc++;
            if (accepted) acc++;
        end
        bus.pix_valid = 1'b0;
        check("feed_count", 32'(acc), 32'(stop_at));
        if (chk_en) begin
            check("en_low_while_filling", {31'b0, en_low_ok}, 32'd1);
            check("en_rise_after_last", {31'b0, bus.en}, 32'd1);
        end
        if (chk_ready_hi) check("ready_during_serve", {31'b0, ready_ok}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_ready"}, {31'b0, bus.pix_ready}, 32'd0);
        check({tag, "_en"}, {31'b0, bus.en}, 32'd0);
        check({tag, "_input_data"}, bus.input_data, 32'd0);
        check({tag, "_frame_cnt"}, {24'b0, bus.frame_cnt}, 32'd0);
    endtask

    initial begin
        bus.pix_in = '0; bus.pix_valid = 1'b0; bus.ack = 1'b0;
        bus.row = '0; bus.col = '0; bus.done = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        check("ready_after_reset", {31'b0, bus.pix_ready}, 32'd1);

        // Frame 1: i mod 256, continuous valid
        feed(1'b0, 1'b0, 6400, 1'b1, 1'b0);
`ifndef WINDOW_FEEDER_DBUF_EN
        repeat (3) begin
            step();
            check("ready_low_in_req", {31'b0, bus.pix_ready}, 32'd0);
        end
`endif
        pulse_done();
        check("done_ignored_cnt", {24'b0, bus.frame_cnt}, 32'd0);
        check("done_ignored_en", {31'b0, bus.en}, 32'd1);
        pulse_ack();
        check("en_drop_after_ack", {31'b0, bus.en}, 32'd0);

        vecs.push_back('{0, 0, 32'h00010203});
        vecs.push_back('{79, 19, 32'hFCFDFEFF});
        vecs.push_back('{80, 3, 32'h0});
        vecs.push_back('{0, 19, 32'h4C4D4E4F});
        vecs.push_back('{1, 0, 32'h50515253});
        vecs.push_back('{10, 7, 32'h3C3D3E3F});
        vecs.push_back('{5, 20, 32'h0});
        vecs.push_back('{127, 127, 32'h0});
        foreach (vecs[i]) begin
            bus.row = 7'(vecs[i].row);
            bus.col = 7'(vecs[i].col);
            step();
            check($sformatf("vec_%0d_%0d", vecs[i].row, vecs[i].col), bus.input_data, vecs[i].exp);
        end
`ifndef WINDOW_FEEDER_DBUF_EN
        check("ready_low_in_serve", {31'b0, bus.pix_ready}, 32'd0);
`endif
        pulse_ack();
        check("ack_ignored_serve", {31'b0, bus.en}, 32'd0);
        pulse_done();
        check("frame_cnt_1", {24'b0, bus.frame_cnt}, 32'd1);
        check("ready_after_done", {31'b0, bus.pix_ready}, 32'd1);

        // Frame 2: same content, randomly gapped valid
        feed(1'b0, 1'b1, 6400, 1'b1, 1'b0);
        pulse_ack();
        read_chk("f2_first", 0, 0);
        read_chk("f2_last", 79, 19);
        random_reads(16);
        pulse_done();
        check("frame_cnt_2", {24'b0, bus.frame_cnt}, 32'd2);

        // Frame 3 aborted by reset part-way through
        feed(1'b1, 1'b1, 3000, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("ready_after_midreset", {31'b0, bus.pix_ready}, 32'd1);

        // Frame 4: random content must land from pixel 0
        feed(1'b1, 1'b1, 6400, 1'b1, 1'b0);
        pulse_ack();
        read_chk("f4_first", 0, 0);
        read_chk("f4_last", 79, 19);
        random_reads(24);

`ifdef WINDOW_FEEDER_DBUF_EN
        // Frame 5 streams into the idle bank while frame 4 is served
        feed(1'b1, 1'b0, 6400, 1'b0, 1'b1);
        step();
        check("ready_low_both_full", {31'b0, bus.pix_ready}, 32'd0);
        pulse_done();
        check("f5_en_after_done", {31'b0, bus.en}, 32'd1);
        check("frame_cnt_after_f4", {24'b0, bus.frame_cnt}, 32'd1);
        pulse_ack();
`else
        bus.pix_valid = 1'b1;
        bus.pix_in    = 8'hAA;
        repeat (8) begin
            step();
            check("ready_low_serve_hold", {31'b0, bus.pix_ready}, 32'd0);
        end
        bus.pix_valid = 1'b0;
        pulse_done();
        check("frame_cnt_after_f4", {24'b0, bus.frame_cnt}, 32'd1);
        check("ready_after_f4_done", {31'b0, bus.pix_ready}, 32'd1);
        feed(1'b1, 1'b0, 6400, 1'b1, 1'b0);
        pulse_ack();
`endif
        read_chk("f5_first", 0, 0);
        read_chk("f5_last", 79, 19);
        random_reads(16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
